// File: rtl/lane_sensor_conditioner_pkg.sv
// Shared definitions for the lane sensor conditioner: channel FSM encoding,
// lane indices and counter width.
package lane_sensor_conditioner_pkg;

    localparam int CNT_W     = 8;
    localparam int NUM_LANES = 4;

    localparam int LANE_NS1 = 0;
    localparam int LANE_NS2 = 1;
    localparam int LANE_EW1 = 2;
    localparam int LANE_EW2 = 3;

    typedef enum logic [1:0] {
        OFF      = 2'd0,
        ON_PEND  = 2'd1,
        ON       = 2'd2,
        OFF_PEND = 2'd3
    } deb_state_t;

endpackage

// File: rtl/lane_sensor_conditioner_debounce.sv
// Single-channel conditioner: 2-flop synchroniser, debounce FSM and run counter.
//
// state    | meaning
// ---------+--------------------------------------------------
// OFF      | output 0, input stable low
// ON_PEND  | output 0, input high, counting towards acceptance
// ON       | output 1, input stable high
// OFF_PEND | output 1, input low, counting towards release
module sensor_debounce
    import lane_sensor_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic level_out
);

    localparam logic [CNT_W-1:0] DEB = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync1_q, sync2_q;
    deb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;

    // Next-state logic; cnt_q stays below DEB, so cnt_q + 1 never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            OFF: begin
                if (sync2_q) begin
                    if (DEB == 8'd1) begin
                        state_d = ON;
                        cnt_d   = '0;
                    end else begin
                        state_d = ON_PEND;
                        cnt_d   = 8'd1;
                    end
                end
            end
            ON_PEND: begin
                if (!sync2_q) begin
                    state_d = OFF;
                    cnt_d   = '0;
                end else if ((cnt_q + 8'd1) >= DEB) begin
                    state_d = ON;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ON: begin
                if (!sync2_q) begin
                    if (DEB == 8'd1) begin
                        state_d = OFF;
                        cnt_d   = '0;
                    end else begin
                        state_d = OFF_PEND;
                        cnt_d   = 8'd1;
                    end
                end
            end
            OFF_PEND: begin
                if (sync2_q) begin
                    state_d = ON;
                    cnt_d   = '0;
                end else if ((cnt_q + 8'd1) >= DEB) begin
                    state_d = OFF;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = OFF;
                cnt_d   = '0;
            end
        endcase
        out_d = (state_d == ON) || (state_d == OFF_PEND);
    end

    // Synchroniser, FSM state, counter and registered output.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= OFF;
            cnt_q   <= '0;
            out_q   <= 1'b0;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign level_out = out_q;

endmodule

// File: rtl/lane_sensor_conditioner.sv
// Conditions the eight raw vehicle-detector inputs into clean levels for the
// traffic light FSM. Build macro SENSOR_FAULT_CHECK_EN adds per-lane
// plausibility checking (queue loop active without the stop-line loop).
module lane_sensor_conditioner
    import lane_sensor_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int FAULT_CYCLES    = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       NS1_S1_raw,
    input  logic       NS2_S1_raw,
    input  logic       EW1_S1_raw,
    input  logic       EW2_S1_raw,
    input  logic       NS1_S5_raw,
    input  logic       NS2_S5_raw,
    input  logic       EW1_S5_raw,
    input  logic       EW2_S5_raw,
    output logic       NS1_S1,
    output logic       NS2_S1,
    output logic       EW1_S1,
    output logic       EW2_S1,
    output logic       NS1_S5,
    output logic       NS2_S5,
    output logic       EW1_S5,
    output logic       EW2_S5,
    output logic [3:0] sensor_fault
);

    logic [NUM_LANES-1:0] raw_s1, raw_s5, deb_s1, deb_s5, s1_out;

    assign raw_s1 = {EW2_S1_raw, EW1_S1_raw, NS2_S1_raw, NS1_S1_raw};
    assign raw_s5 = {EW2_S5_raw, EW1_S5_raw, NS2_S5_raw, NS1_S5_raw};

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_s1 (
            .clk(clk), .rst(rst), .raw_in(raw_s1[l]), .level_out(deb_s1[l])
        );
        sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_s5 (
            .clk(clk), .rst(rst), .raw_in(raw_s5[l]), .level_out(deb_s5[l])
        );
    end

`ifdef SENSOR_FAULT_CHECK_EN
    localparam logic [CNT_W-1:0] FLT = CNT_W'(FAULT_CYCLES);

    logic [CNT_W-1:0]     fcnt_q [NUM_LANES];
    logic [CNT_W-1:0]     fcnt_d [NUM_LANES];
    logic [NUM_LANES-1:0] flag;
    logic [NUM_LANES-1:0] force_q;

    // Saturating run counter of "queue without presence"; judged on the
    // debounced S1, not the forced one, so forcing cannot mask the fault.
    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            fcnt_d[l] = '0;
            if (deb_s5[l] && !deb_s1[l]) begin
                fcnt_d[l] = (fcnt_q[l] == FLT) ? FLT : fcnt_q[l] + 8'd1;
            end
            flag[l] = (fcnt_q[l] == FLT);
        end
    end

    // Fault counters, plus a one-cycle tail so forced S1 drops after the flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int l = 0; l < NUM_LANES; l++) fcnt_q[l] <= '0;
            force_q <= '0;
        end else begin
            for (int l = 0; l < NUM_LANES; l++) fcnt_q[l] <= fcnt_d[l];
            force_q <= flag;
        end
    end

    assign sensor_fault = flag;
    assign s1_out       = deb_s1 | flag | force_q;
`else
    // Check disabled: fault port tied low; FAULT_CYCLES is irrelevant here.
    assign sensor_fault = 4'(FAULT_CYCLES) & 4'b0000;
    assign s1_out       = deb_s1;
`endif

    assign NS1_S1 = s1_out[LANE_NS1];
    assign NS2_S1 = s1_out[LANE_NS2];
    assign EW1_S1 = s1_out[LANE_EW1];
    assign EW2_S1 = s1_out[LANE_EW2];
    assign NS1_S5 = deb_s5[LANE_NS1];
    assign NS2_S5 = deb_s5[LANE_NS2];
    assign EW1_S5 = deb_s5[LANE_EW1];
    assign EW2_S5 = deb_s5[LANE_EW2];

endmodule

// File: tb/tb_lane_sensor_conditioner.sv
// Self-checking bench for lane_sensor_conditioner (DEBOUNCE_CYCLES=4,
// FAULT_CYCLES=8). Vector bit order: [3:0] = S1 of NS1,NS2,EW1,EW2;
// [7:4] = S5 of NS1,NS2,EW1,EW2.
module tb_lane_sensor_conditioner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] raw = 8'h00;
    logic [7:0] out;
    logic [3:0] sensor_fault;
    logic       ns1_s1, ns2_s1, ew1_s1, ew2_s1, ns1_s5, ns2_s5, ew1_s5, ew2_s5;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] raw;
        logic [7:0] exp;
    } vec_t;

    vec_t       tbl [10];
    logic [7:0] sbq [$];

    always #5 clk = ~clk;

    lane_sensor_conditioner #(.DEBOUNCE_CYCLES(4), .FAULT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .NS1_S1_raw(raw[0]), .NS2_S1_raw(raw[1]), .EW1_S1_raw(raw[2]), .EW2_S1_raw(raw[3]),
        .NS1_S5_raw(raw[4]), .NS2_S5_raw(raw[5]), .EW1_S5_raw(raw[6]), .EW2_S5_raw(raw[7]),
        .NS1_S1(ns1_s1), .NS2_S1(ns2_s1), .EW1_S1(ew1_s1), .EW2_S1(ew2_s1),
        .NS1_S5(ns1_s5), .NS2_S5(ns2_s5), .EW1_S5(ew1_s5), .EW2_S5(ew2_s5),
        .sensor_fault(sensor_fault)
    );

    assign out = {ew2_s5, ew1_s5, ns2_s5, ns1_s5, ew2_s1, ew1_s1, ns2_s1, ns1_s1};

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int waited;

        tbl[0] = '{8'h00, 8'h00};
        tbl[1] = '{8'hFF, 8'hFF};
        tbl[2] = '{8'h0F, 8'h0F};
        tbl[3] = '{8'h33, 8'h33};
        tbl[4] = '{8'h5F, 8'h5F};
        tbl[5] = '{8'h11, 8'h11};
        tbl[6] = '{8'hCC, 8'hCC};
        tbl[7] = '{8'h0A, 8'h0A};
        tbl[8] = '{8'hFF, 8'hFF};
        tbl[9] = '{8'h00, 8'h00};

        // 1. reset with all raw inputs high
        rst = 1'b1;
        raw = 8'hFF;
        tick(2);
        chk("reset_outputs", out, 8'h00);
        chk("reset_fault", {4'h0, sensor_fault}, 8'h00);
        raw = 8'h00;
        tick(1);
        rst = 1'b0;
        tick(8);
        chk("post_reset_idle", out, 8'h00);

        // 2. clean assert / deassert latency on NS1_S1
        raw = 8'h01;
        tick(5);
        chk("assert_k+4", out, 8'h00);
        tick(1);
        chk("assert_k+5", out, 8'h01);
        raw = 8'h00;
        tick(5);
        chk("deassert_k+4", out, 8'h01);
        tick(1);
        chk("deassert_k+5", out, 8'h00);

        // 3. 3-cycle pulse on EW2_S5 rejected
        raw = 8'h80;
        tick(3);
        raw = 8'h00;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("glitch_reject", out, 8'h00);
        end
        // 1-cycle dip during ON ignored
        raw = 8'h88;
        tick(8);
        chk("dip_pre", out, 8'h88);
        raw = 8'h08;
        tick(1);
        raw = 8'h88;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk("dip_hold", out, 8'h88);
        end
        raw = 8'h00;
        tick(8);
        chk("dip_release", out, 8'h00);

        // 4. all inputs together, then a 2-cycle low pulse on NS2_S1
        raw = 8'hFF;
        tick(5);
        chk("all_k+4", out, 8'h00);
        tick(1);
        chk("all_k+5", out, 8'hFF);
        raw = 8'hFD;
        tick(2);
        raw = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk("indep_hold", out, 8'hFF);
        end
        raw = 8'h00;
        tick(8);
        chk("all_release", out, 8'h00);

        // 5. reset in the middle of a pending rise on EW1_S1
        raw = 8'h04;
        tick(3);
        chk("pend_before_rst", out, 8'h00);
        rst = 1'b1;
        tick(1);
        chk("pend_in_rst", out, 8'h00);
        rst = 1'b0;
        tick(5);
        chk("pend_rst_k+4", out, 8'h00);
        tick(1);
        chk("pend_rst_k+5", out, 8'h04);
        raw = 8'h00;
        tick(8);

        // table-driven steady-state vectors through the scoreboard
        for (int v = 0; v < 10; v++) begin
            raw = tbl[v].raw;
            sbq.push_back(tbl[v].exp);
            tick(8);
            chk($sformatf("table_%0d", v), out, sbq.pop_front());
            chk($sformatf("table_fault_%0d", v), {4'h0, sensor_fault}, 8'h00);
        end

        // 6. plausibility check on NS2: queue loop without presence loop
        raw = 8'h20;
`ifdef SENSOR_FAULT_CHECK_EN
        waited = 0;
        while (!sensor_fault[1] && waited < 40) begin
            tick(1);
            waited++;
        end
        chk("fault_set", {4'h0, sensor_fault}, 8'h02);
        chk("fault_latency", 8'(waited), 8'd14);
        chk("fault_forced_s1", out, 8'h22);
        tick(5);
        chk("fault_hold", out, 8'h22);
        raw = 8'h00;
        waited = 0;
        while (sensor_fault[1] && waited < 40) begin
            tick(1);
            waited++;
        end
        chk("fault_clear", {4'h0, sensor_fault}, 8'h00);
        chk("fault_s1_tail", out, 8'h02);
        tick(1);
        chk("fault_s1_drop", out, 8'h00);
`else
        waited = 0;
        tick(20);
        chk("nofault_flag", {4'h0, sensor_fault}, 8'h00);
        chk("nofault_s1", out, 8'h20);
        raw = 8'h00;
        tick(8);
        chk("nofault_release", out, 8'h00);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
